// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [FETCH_XLEN-1:0] word_align(input logic [FETCH_XLEN-1:0] addr);
    return {addr[FETCH_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, inst} entries; flush wins over push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// In-order instruction fetch: PC, request credit, wrong-path discard and output register.
// state | meaning
// BOOT  | single idle cycle after reset, no request
// RUN   | normal fetch, every response is buffered
// DRAIN | wrong-path responses still due; discard_cnt counts them down
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN       = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc_out,
  output logic            inst_valid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = CNT_W + 1;

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic [XLEN-1:0]  pc_out_q, pc_out_d;
  logic             valid_q, valid_d;

  logic             accept, rsp, rsp_keep;
  logic [XLEN-1:0]  redirect_word;
  logic [CRD_W-1:0] credit_used;
  logic             fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_wdata, fifo_head;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Credit covers words in flight plus words already buffered, so a response always has room.
  assign credit_used   = CRD_W'(outstanding_q) + CRD_W'(fifo_count);
  assign imem_req      = (state_q != BOOT) && (credit_used < CRD_W'(FIFO_DEPTH));
  assign imem_addr     = fetch_pc_q;
  assign accept        = imem_req && imem_gnt;
  assign rsp           = imem_rvalid && (outstanding_q != '0);
  assign outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp);
  assign redirect_word = word_align(redirect_pc);
  assign fifo_wdata    = '{pc: rsp_pc_q, inst: imem_rdata};
  assign fifo_push     = rsp_keep && !fifo_full;

  assign instruction = inst_q;
  assign pc_out      = pc_out_q;
  assign inst_valid  = valid_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    fifo_flush = 1'b0;
    fifo_pop   = 1'b0;
    rsp_keep   = 1'b0;

    if (accept) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    if (redirect_valid) begin
      // Everything still in flight, including this cycle's accept, is wrong-path.
      fifo_flush = 1'b1;
      fetch_pc_d = redirect_word;
      rsp_pc_d   = redirect_word;
      discard_d  = outstanding_d;
      state_d    = (outstanding_d != '0) ? DRAIN : RUN;
      inst_d     = NOP_INST;
      valid_d    = 1'b0;
    end else begin
      if (state_q == BOOT) begin
        state_d = RUN;
      end
      if (rsp) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
          if (discard_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end else begin
          rsp_keep = 1'b1;
          rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
      end
      if (!stall) begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          inst_d   = fifo_head.inst;
          pc_out_d = fifo_head.pc;
          valid_d  = 1'b1;
        end else begin
          inst_d  = NOP_INST;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      inst_q        <= NOP_INST;
      pc_out_q      <= '0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      inst_q        <= inst_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that feeds the microcoded controller and the datapath with `instruction` and `pc_out`.
- Owns the PC and issues in-order word requests to instruction memory over a req/gnt + rvalid handshake.
- Buffers returned words in a small FIFO and holds its output while the controller stalls for multi-cycle microcode (load/store/memcp).
- Drops wrong-path words on a branch/jump redirect and presents all-zero bubbles, which decode to all-zero control signals.

Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; also caps outstanding + buffered words.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset. Asynchronous, active-low.
- stall  in  1  hold the output register. Driven high while the controller's microcode is in a stay sequence.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] are ignored (forced 0).
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  word-aligned fetch address.
- imem_gnt  in  1  request accepted when imem_req && imem_gnt.
- imem_rvalid  in  1  response valid; responses return strictly in request order.
- imem_rdata  in  XLEN  instruction word.
- instruction  out  XLEN  instruction to the controller/decode; 0 when not valid.
- pc_out  out  XLEN  PC of `instruction`.
- inst_valid  out  1  instruction is a real fetched word.

Behaviour:
- Reset (async, rstn low): state=BOOT, fetch_pc=RESET_PC, outstanding=0, discard_cnt=0, FIFO empty, instruction=0, pc_out=0, inst_valid=0, imem_req=0, imem_addr=RESET_PC.
- Reset asserted mid-operation aborts everything immediately. Responses arriving after reset release are not counted and are ignored.
- States:
  - BOOT: one cycle, no request; goes to RUN.
  - RUN: normal fetch.
  - DRAIN: discard_cnt>0; requests continue. Moves to RUN when discard_cnt reaches 0 on a consumed rvalid.
- Request: imem_req = (state!=BOOT) && (outstanding + fifo_count < FIFO_DEPTH). imem_addr = fetch_pc, combinational from registers.
- On accept: fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 0. The request PC is stored in a PC queue alongside the data.
- outstanding_next = outstanding + accept - rvalid. An rvalid with outstanding==0 is ignored.
- Response handling:
  - If discard_cnt>0: the word is dropped and discard_cnt decrements.
  - Otherwise: {pc, data} is pushed into the FIFO at the end of the cycle.
- Output register advances when !stall:
  - FIFO non-empty: pop the head into instruction/pc_out and set inst_valid=1.
  - FIFO empty: instruction=0, inst_valid=0, pc_out holds.
- stall=1: instruction/pc_out/inst_valid are held; requests continue until credit is exhausted.
- Redirect (has priority over stall and over every other event in that cycle):
  - At the clock edge: FIFO flushed, output register set to bubble (instruction=0, inst_valid=0), fetch_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - discard_cnt = outstanding_next. This counts a request accepted in the redirect cycle; an rvalid in the redirect cycle is dropped, not pushed.
  - state = DRAIN if outstanding_next>0, else RUN.
  - The first request to the new PC is issued the cycle after redirect.
- Redirect while in DRAIN recomputes discard_cnt the same way.
- Latency with zero-wait memory (gnt=1, rvalid one cycle after accept):
  - Accept in cycle c, rvalid in c+1, FIFO write at end of c+1, output visible in c+3.
  - Throughput is one instruction per cycle with stall=0.
- FIFO full and push are mutually exclusive by construction (credit rule). The bench checks this with an assertion.

Decomposition:
- fetch_pkg holds:
  - XLEN default and NOP_INST = 32'h0000_0000.
  - fetch_state_t enum {BOOT, RUN, DRAIN}.
  - typedef fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports push/pop/flush/count/empty/full.
  - flush has priority over push.
- fetch_stage holds PC, credit, discard counter, FSM and output register.

Test Plan:
- Reset then zero-wait memory returning imem_rdata = addr: first imem_req in cycle 2 after rstn rise, addr 0. Output pc_out=0/instruction=0 valid 3 cycles after the first accept, then 4, 8, 12 on consecutive cycles.
- stall held 5 cycles at pc_out=8: output stays 8. Requests stop once outstanding+count=4. After release, 12, 16, 20, 24 follow with no gap or duplicate.
- Memory latency 3 cycles, redirect_valid with redirect_pc=32'h100 while 3 requests are outstanding: the 3 stale responses are dropped. Next valid output has pc_out=32'h100; inst_valid is 0 in between.
- Redirect and stall high in the same cycle, redirect_pc=32'h203: output becomes bubble (instruction=0) despite stall. Next fetch addr is 32'h200.
- RESET_PC=32'hFFFF_FFF8: outputs FFFF_FFF8, FFFF_FFFC, 0000_0000 in sequence.
- rstn pulsed low mid-DRAIN with 2 responses in flight: outputs return to reset values immediately. The late rvalids are ignored and the first valid output is RESET_PC.
